// File: rtl/decode.sv
// Instruction decode stage: register file with writeback bypass, control decode,
// branch/jump resolution, hazard stall detection and the ID/EX pipeline register.
module decode (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] if_id_instruc,
   input  logic [31:0] if_id_nextpc,
   input  logic        wb_id_writereg,
   input  logic [4:0]  wb_id_regdest,
   input  logic [31:0] wb_id_writedata,
   output logic        id_stall,
   output logic        id_if_selpcsource,
   output logic [1:0]  id_if_selpctype,
   output logic [31:0] id_if_pcimd2ext,
   output logic [31:0] id_if_rega,
   output logic [31:0] id_if_pcindex,
   output logic [31:0] id_ex_rega,
   output logic [31:0] id_ex_regb,
   output logic [31:0] id_ex_imedext,
   output logic [31:0] id_ex_nextpc,
   output logic [4:0]  id_ex_regdest,
   output logic [2:0]  id_ex_aluop,
   output logic        id_ex_writereg,
   output logic        id_ex_memread,
   output logic        id_ex_memwrite,
   output logic        id_ex_selimm,
   output logic [31:0] id_epc
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   logic [31:0] r_regs [0:31];
   logic [31:0] r_rega, r_regb, r_imedext, r_nextpc, r_epc;
   logic [4:0]  r_regdest;
   logic [2:0]  r_aluop;
   logic        r_writereg, r_memread, r_memwrite, r_selimm;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_rs_val, w_rt_val, w_imedext;
   logic        w_rtype, w_add, w_sub, w_and, w_or, w_slt, w_jr;
   logic        w_addi, w_lw, w_sw, w_beq, w_bne, w_j, w_nop;
   logic        w_alu_r, w_issue, w_illegal, w_uses_rs, w_uses_rt;
   logic        w_load_hazard, w_branch_hazard, w_stall, w_taken;
   logic [4:0]  w_dest;
   logic [2:0]  w_aluop;
   logic [1:0]  w_pctype;

   assign w_op      = if_id_instruc[31:26];
   assign w_rs      = if_id_instruc[25:21];
   assign w_rt      = if_id_instruc[20:16];
   assign w_rd      = if_id_instruc[15:11];
   assign w_funct   = if_id_instruc[5:0];
   assign w_imedext = {{16{if_id_instruc[15]}}, if_id_instruc[15:0]};

   // Same-cycle writeback is forwarded so decode never sees a stale value.
   always_comb begin
      w_rs_val = r_regs[w_rs];
      w_rt_val = r_regs[w_rt];
      if (wb_id_writereg && (wb_id_regdest == w_rs)) w_rs_val = wb_id_writedata;
      if (wb_id_writereg && (wb_id_regdest == w_rt)) w_rt_val = wb_id_writedata;
      if (w_rs == 5'd0) w_rs_val = 32'd0;
      if (w_rt == 5'd0) w_rt_val = 32'd0;
   end

   assign w_nop   = (if_id_instruc == 32'd0);
   assign w_rtype = (w_op == 6'h00);
   assign w_add   = w_rtype && (w_funct == 6'h20);
   assign w_sub   = w_rtype && (w_funct == 6'h22);
   assign w_and   = w_rtype && (w_funct == 6'h24);
   assign w_or    = w_rtype && (w_funct == 6'h25);
   assign w_slt   = w_rtype && (w_funct == 6'h2A);
   assign w_jr    = w_rtype && (w_funct == 6'h08);
   assign w_addi  = (w_op == 6'h08);
   assign w_lw    = (w_op == 6'h23);
   assign w_sw    = (w_op == 6'h2B);
   assign w_beq   = (w_op == 6'h04);
   assign w_bne   = (w_op == 6'h05);
   assign w_j     = (w_op == 6'h02);

   assign w_alu_r   = w_add || w_sub || w_and || w_or || w_slt;
   assign w_issue   = w_alu_r || w_addi || w_lw || w_sw;
   assign w_illegal = !(w_nop || w_issue || w_jr || w_beq || w_bne || w_j);
   assign w_uses_rs = w_alu_r || w_jr || w_addi || w_lw || w_sw || w_beq || w_bne;
   assign w_uses_rt = w_alu_r || w_sw || w_beq || w_bne;

   assign w_load_hazard = r_memread && (r_regdest != 5'd0) &&
                          ((w_uses_rs && (r_regdest == w_rs)) ||
                           (w_uses_rt && (r_regdest == w_rt)));
   assign w_branch_hazard = (w_beq || w_bne || w_jr) && r_writereg &&
                            ((r_regdest == w_rs) ||
                             ((w_beq || w_bne) && (r_regdest == w_rt)));
   assign w_stall = w_load_hazard || w_branch_hazard;

   always_comb begin
      w_aluop = ALU_ADD;
      if (w_sub) w_aluop = ALU_SUB;
      if (w_and) w_aluop = ALU_AND;
      if (w_or)  w_aluop = ALU_OR;
      if (w_slt) w_aluop = ALU_SLT;
      w_dest = 5'd0;
      if (w_alu_r)        w_dest = w_rd;
      if (w_addi || w_lw) w_dest = w_rt;
      w_taken  = 1'b0;
      w_pctype = 2'b00;
      if (w_beq && (w_rs_val == w_rt_val)) w_taken = 1'b1;
      if (w_bne && (w_rs_val != w_rt_val)) w_taken = 1'b1;
      if (w_jr) begin
         w_taken  = 1'b1;
         w_pctype = 2'b01;
      end
      if (w_j) begin
         w_taken  = 1'b1;
         w_pctype = 2'b10;
      end
      if (w_illegal) begin
         w_taken  = 1'b1;
         w_pctype = 2'b11;
      end
   end

   assign id_stall          = w_stall;
   assign id_if_selpcsource = w_taken && !w_stall;
   assign id_if_selpctype   = w_pctype;
   assign id_if_pcimd2ext   = if_id_nextpc + {w_imedext[29:0], 2'b00};
   assign id_if_rega        = w_rs_val;
   assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (wb_id_writereg && (wb_id_regdest != 5'd0)) begin
         r_regs[wb_id_regdest] <= wb_id_writedata;
      end
   end

   // Branches, jumps, NOPs, illegal words and stalls all send a bubble to EX.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rega <= 32'd0; r_regb <= 32'd0; r_imedext <= 32'd0; r_nextpc <= 32'd0;
         r_regdest <= 5'd0; r_aluop <= 3'd0; r_writereg <= 1'b0;
         r_memread <= 1'b0; r_memwrite <= 1'b0; r_selimm <= 1'b0; r_epc <= 32'd0;
      end else begin
         if (w_stall || !w_issue) begin
            r_rega <= 32'd0; r_regb <= 32'd0; r_imedext <= 32'd0; r_nextpc <= 32'd0;
            r_regdest <= 5'd0; r_aluop <= 3'd0; r_writereg <= 1'b0;
            r_memread <= 1'b0; r_memwrite <= 1'b0; r_selimm <= 1'b0;
         end else begin
            r_rega     <= w_rs_val;
            r_regb     <= w_rt_val;
            r_imedext  <= w_imedext;
            r_nextpc   <= if_id_nextpc;
            r_regdest  <= w_dest;
            r_aluop    <= w_aluop;
            r_writereg <= (w_alu_r || w_addi || w_lw) && (w_dest != 5'd0);
            r_memread  <= w_lw;
            r_memwrite <= w_sw;
            r_selimm   <= w_addi || w_lw || w_sw;
         end
         if (w_illegal && !w_stall) r_epc <= if_id_nextpc - 32'd4;
      end
   end

   assign id_ex_rega     = r_rega;
   assign id_ex_regb     = r_regb;
   assign id_ex_imedext  = r_imedext;
   assign id_ex_nextpc   = r_nextpc;
   assign id_ex_regdest  = r_regdest;
   assign id_ex_aluop    = r_aluop;
   assign id_ex_writereg = r_writereg;
   assign id_ex_memread  = r_memread;
   assign id_ex_memwrite = r_memwrite;
   assign id_ex_selimm   = r_selimm;
   assign id_epc         = r_epc;

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters: none; exception vector 0x0000_0040 is fixed in the fetch stage.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-004 if_id_instruc  in  32  instruction word from fetch.
REQ-005 if_id_nextpc  in  32  address of that instruction plus 4.
REQ-006 wb_id_writereg  in  1  writeback write enable.
REQ-007 wb_id_regdest  in  5  writeback destination register.
REQ-008 wb_id_writedata  in  32  writeback data.
REQ-009 id_stall  out  1  combinational hold request to fetch.
REQ-010 id_if_selpcsource  out  1  combinational PC redirect request.
REQ-011 id_if_selpctype  out  2  redirect type: 00 branch, 01 jr, 10 jump, 11 exception.
REQ-012 id_if_pcimd2ext  out  32  branch target.
REQ-013 id_if_rega  out  32  rs value, used as the jr target.
REQ-014 id_if_pcindex  out  32  jump target.
REQ-015 id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_nextpc  out  32 each  registered operands.
REQ-016 id_ex_regdest  out  5;  id_ex_aluop  out  3;  id_ex_writereg, id_ex_memread, id_ex_memwrite, id_ex_selimm  out  1 each  registered controls.
REQ-017 id_epc  out  32  address of the last illegal instruction.

Function
REQ-018 Register file: 32x32, two combinational read ports (rs = instr[25:21], rt = instr[20:16]).
- Write occurs on posedge when wb_id_writereg=1 and wb_id_regdest!=0.
- Register 0 always reads 0.
- A same-cycle write to rs or rt is bypassed to the read port.
REQ-019 Decoded opcodes:
- op 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
- addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- Any other opcode/funct is illegal.
- Encoding 0x0000_0000 is a NOP (sll r0): no write, no redirect.
REQ-020 aluop encoding: add 000, sub 001, and 010, or 011, slt 100.
- addi, lw and sw use add.
- beq, bne, j and jr issue a bubble to EX.
REQ-021 id_ex_regdest: rd for R-type, rt for addi/lw, 0 otherwise.
- id_ex_writereg=1 only for add/sub/and/or/slt/addi/lw with regdest!=0.
REQ-022 id_ex_imedext = sign-extended instr[15:0]; id_ex_selimm=1 for addi/lw/sw.
REQ-023 Targets:
- id_if_pcimd2ext = if_id_nextpc + (imedext<<2), 32-bit wrap.
- id_if_pcindex = {if_id_nextpc[31:28], instr[25:0], 2'b00}.
REQ-024 id_if_selpcsource=1 when any of the following holds, gated to 0 while id_stall=1:
- beq with rs==rt (type 00);
- bne with rs!=rt (type 00);
- jr (type 01);
- j (type 10);
- illegal instruction (type 11).
REQ-025 One delay slot: the instruction fetched in the redirect cycle executes; there is no flush.
REQ-026 id_stall=1 (combinational) in either case:
- id_ex_memread=1, id_ex_regdest!=0, and id_ex_regdest equals a source used by the current instruction;
- the current instruction is beq/bne/jr, id_ex_writereg=1, and id_ex_regdest equals rs, or equals rt for beq/bne.
REQ-027 Stall cycle: the id_ex_* registers load a bubble (all controls 0, data 0); the current instruction is held and re-evaluated next cycle.
REQ-028 Non-stall cycle: id_ex_* registers capture the decoded values on posedge (latency 1 cycle).
REQ-029 Illegal instruction: on posedge, id_epc <= if_id_nextpc - 4 and EX receives a bubble.
- If an illegal instruction occurs in a stall cycle, id_epc is not updated.

Reset
REQ-030 reset=0 asynchronously clears all 32 registers, id_epc and every id_ex_* output to 0.
REQ-031 Combinational outputs follow the inputs during reset, except id_stall, which evaluates 0 because id_ex_* are 0.
REQ-032 Deasserting reset mid-operation resumes from the cleared state; no partial writeback is retained.

Verification
REQ-033 Writeback r5=0x1234, then decode "add r6,r5,r5" -> next cycle id_ex_rega=id_ex_regb=0x1234, aluop=000, regdest=6, writereg=1.
REQ-034 Writeback r3 in the same cycle as "beq r3,r0" decode with data 0 -> bypass gives equality, selpcsource=1, type 00, pcimd2ext=nextpc+(imm<<2).
REQ-035 Decode "lw r2,0(r1)" then "add r4,r2,r2" -> id_stall=1 for exactly one cycle, bubble in id_ex, add issues the following cycle.
REQ-036 Decode "j 0x100" at nextpc 0x8000_0010 -> selpcsource=1, type 10, pcindex=0x8000_0400.
REQ-037 Decode opcode 0x3F at nextpc 0x24 -> type 11 redirect, id_epc=0x20 next cycle, bubble to EX.
REQ-038 Write r0 via writeback, then read it -> reads 0; assert reset mid-stream -> all id_ex_* = 0 immediately.
